jk_bank_sched: RTL and testbench

JK_BANK_SCHED -- requirements
Module: jk_bank_sched

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 23 ++
 rtl/jk_bank_sched.sv | 118 +++++++++++
 tb/tb_jk_bank_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK bank scheduler: command encoding and FSM states.
package jk_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_HOLD = 2'b00;
   localparam op_t OP_CLR  = 2'b01;
   localparam op_t OP_SET  = 2'b10;
   localparam op_t OP_TGL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/jk_cell.sv
// One rising-edge JK flip-flop bit with synchronous active-low reset.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that lets NREQ requesters take turns driving a shared
// W-bit JK flip-flop bank, one IDLE->DRIVE->DONE command at a time.
module jk_bank_sched
   import jk_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] op,
   input  logic [W*NREQ-1:0] mask,
   output logic [NREQ-1:0]   gnt,
   output logic              done,
   output logic [W-1:0]      j,
   output logic [W-1:0]      k,
   output logic [W-1:0]      q
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win;
   op_t             lat_op;
   logic [W-1:0]    lat_mask;

   logic            any_req;
   logic            found;
   logic [IW-1:0]   cand;
   logic [IW-1:0]   win_nxt;
   op_t             op_sel;
   logic [W-1:0]    mask_sel;

   // Search upward from the pointer with wrap-around; first active req wins.
   always_comb begin
      any_req  = |req;
      found    = 1'b0;
      cand     = '0;
      win_nxt  = ptr;
      op_sel   = OP_HOLD;
      mask_sel = '0;
      for (int o = 0; o < NREQ; o++) begin
         cand = IW'((int'(ptr) + o) % NREQ);
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_nxt = cand;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (win_nxt == IW'(i)) begin
            op_sel   = op[2*i +: 2];
            mask_sel = mask[W*i +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         win      <= '0;
         lat_op   <= OP_HOLD;
         lat_mask <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state    <= ST_DRIVE;
                  win      <= win_nxt;
                  lat_op   <= op_sel;
                  lat_mask <= mask_sel;
                  ptr      <= (int'(win_nxt) == NREQ - 1) ? '0 : win_nxt + 1'b1;
               end
            end
            ST_DRIVE: state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of the registered state, so reset clears them too.
   always_comb begin
      gnt  = '0;
      j    = '0;
      k    = '0;
      done = (state == ST_DONE);
      if (state == ST_DRIVE) begin
         for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (win == IW'(i));
         end
         case (lat_op)
            OP_CLR: k = lat_mask;
            OP_SET: j = lat_mask;
            OP_TGL: begin
               j = lat_mask;
               k = lat_mask;
            end
            default: begin
               j = '0;
               k = '0;
            end
         endcase
      end
   end

   for (genvar b = 0; b < W; b++) begin : g_bank
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j[b]),
         .k     (k[b]),
         .q     (q[b])
      );
   end

endmodule

// File: tb/tb_jk_bank_sched.sv
// Scoreboard bench for jk_bank_sched: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever gnt or done appears.
module tb_jk_bank_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [15:0] mask;
   logic [3:0]  gnt;
   logic        done;
   logic [3:0]  j;
   logic [3:0]  k;
   logic [3:0]  q;

   typedef struct {
      bit         isDone;
      logic [3:0] gnt;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] q;
   } exp_t;

   exp_t sb[$];
   int   testCount = 0;
   int   failCount = 0;
   int   doneCount = 0;
   int   doneBase;

   jk_bank_sched #(.NREQ(4), .W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .op    (op),
      .mask  (mask),
      .gnt   (gnt),
      .done  (done),
      .j     (j),
      .k     (k),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Monitor: every gnt or done presentation must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (gnt != 4'b0000 || done) begin
         testCount++;
         if (sb.size() == 0) begin
            failCount++;
            $display("[TB] FAIL unexpected_output got gnt=%b done=%b j=%b k=%b q=%b, want nothing", gnt, done, j, k, q);
         end else begin
            e = sb.pop_front();
            if (e.isDone) begin
               if (!(done && gnt == 4'b0000 && q == e.q)) begin
                  failCount++;
                  $display("[TB] FAIL done_q got done=%b gnt=%b q=%b, want done=1 gnt=0000 q=%b", done, gnt, q, e.q);
               end
            end else begin
               if (!(!done && gnt == e.gnt && j == e.j && k == e.k)) begin
                  failCount++;
                  $display("[TB] FAIL drive got gnt=%b j=%b k=%b done=%b, want gnt=%b j=%b k=%b done=0", gnt, j, k, done, e.gnt, e.j, e.k);
               end
            end
         end
         if (done) doneCount++;
      end else if (j != 4'b0000 || k != 4'b0000) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL idle_jk got j=%b k=%b, want 0000 while gnt=0000", j, k);
      end
   end

   task automatic waitStim();
      @(negedge clk);
      #2;
   endtask

   task automatic pushDrive(input logic [3:0] g, input logic [3:0] jj, input logic [3:0] kk);
      exp_t e;
      e.isDone = 1'b0; e.gnt = g; e.j = jj; e.k = kk; e.q = 4'b0000;
      sb.push_back(e);
   endtask

   task automatic pushDone(input logic [3:0] qq);
      exp_t e;
      e.isDone = 1'b1; e.gnt = 4'b0000; e.j = 4'b0000; e.k = 4'b0000; e.q = qq;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [7:0] o, input logic [15:0] m);
      req  = r;
      op   = o;
      mask = m;
      waitStim();
      req = 4'b0000;
      waitStim();
      waitStim();
   endtask

   task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
      testCount++;
      if (got !== want) begin
         failCount++;
         $display("[TB] FAIL %s got %b, want %b", name, got, want);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      op    = 8'h00;
      mask  = 16'h0000;
      repeat (2) @(posedge clk);
      waitStim();
      checkOutput("reset_q", q, 4'b0000);
      checkOutput("reset_gnt", gnt, 4'b0000);
      checkOutput("reset_done", {3'b000, done}, 4'b0000);
      rst_n = 1'b1;

      // Single SET from requester 0, mask 0101
      pushDrive(4'b0001, 4'b0101, 4'b0000);
      pushDone(4'b0101);
      applyStimulus(4'b0001, 8'b00_00_00_10, 16'h0005);

      // Toggle from requester 1, mask 1111
      pushDrive(4'b0010, 4'b1111, 4'b1111);
      pushDone(4'b1010);
      applyStimulus(4'b0010, 8'b00_00_11_00, 16'h00F0);

      // HOLD from requester 3 with a nonzero mask still completes; pointer wraps to 0
      pushDrive(4'b1000, 4'b0000, 4'b0000);
      pushDone(4'b1010);
      applyStimulus(4'b1000, 8'b00_00_00_00, 16'hF000);

      // Requesters 0 (CLR 0011) and 2 (SET 0110) held across two commands
      pushDrive(4'b0001, 4'b0000, 4'b0011);
      pushDone(4'b1000);
      pushDrive(4'b0100, 4'b0110, 4'b0000);
      pushDone(4'b1110);
      req  = 4'b0101;
      op   = 8'b00_10_00_01;
      mask = 16'h0603;
      repeat (4) waitStim();
      req = 4'b0000;
      repeat (2) waitStim();

      // Pointer now 3: requester 3 HOLD with zero mask beats requester 0
      pushDrive(4'b1000, 4'b0000, 4'b0000);
      pushDone(4'b1110);
      applyStimulus(4'b1001, 8'b00_00_00_10, 16'h000F);

      // All four requesting for 12 cycles
      pushDrive(4'b0001, 4'b0001, 4'b0000);
      pushDone(4'b1111);
      pushDrive(4'b0010, 4'b0000, 4'b0110);
      pushDone(4'b1001);
      pushDrive(4'b0100, 4'b1100, 4'b1100);
      pushDone(4'b0101);
      pushDrive(4'b1000, 4'b0011, 4'b0011);
      pushDone(4'b0110);
      doneBase = doneCount;
      req  = 4'b1111;
      op   = 8'b11_11_01_10;
      mask = 16'h3C61;
      repeat (12) waitStim();
      req = 4'b0000;
      checkOutput("all_req_done_pulses", 4'(doneCount - doneBase), 4'd4);
      waitStim();

      // Reset during DRIVE of SET 1111 aborts the command
      pushDrive(4'b0001, 4'b1111, 4'b0000);
      req  = 4'b0001;
      op   = 8'b00_00_00_10;
      mask = 16'h000F;
      waitStim();
      req   = 4'b0000;
      rst_n = 1'b0;
      waitStim();
      rst_n = 1'b1;
      checkOutput("abort_q", q, 4'b0000);
      checkOutput("abort_done", {3'b000, done}, 4'b0000);
      waitStim();
      checkOutput("abort_no_done", {3'b000, done}, 4'b0000);

      // Pointer back at 0: requester 0 beats requester 1
      pushDrive(4'b0001, 4'b0001, 4'b0000);
      pushDone(4'b0001);
      applyStimulus(4'b0011, 8'b00_00_10_10, 16'h0021);

      repeat (3) waitStim();
      checkOutput("scoreboard_drained", 4'(sb.size()), 4'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
